// File: rtl/intc_pkg.sv
// intc_pkg: PerInt op codes, intc commands, FSM states and index-width helper.
package intc_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    localparam logic CMDACKINT   = 1'b0;
    localparam logic CMDGETCOUNT = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAITACK = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intc_rrarb.sv
// intc_rrarb: combinational pick of one pending source, scanning upward from ptr+1 with wrap.
// Ports: req (pending sources), ptr (last serviced index), idx (picked source), valid (any pending).
// INTC_FIXEDPRIO_EN: when defined, always picks the lowest pending index and ignores ptr.
module intc_rrarb
    import intc_pkg::*;
#(
    parameter int SRCCOUNT = 2,
    parameter int IW = idx_w(SRCCOUNT)
) (
    input  logic [SRCCOUNT-1:0] req,
    input  logic [IW-1:0]       ptr,
    output logic [IW-1:0]       idx,
    output logic                valid
);

`ifdef INTC_FIXEDPRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Descending loop so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        valid = 1'b0;
        for (int i = SRCCOUNT - 1; i >= 0; i--) begin
            if (((req >> i) & SRCCOUNT'(1)) != '0) begin
                idx = IW'(i);
                valid = 1'b1;
            end
        end
    end
`else
    // Descending scan distance so the nearest source after ptr wins.
    always_comb begin
        int j;
        idx = '0;
        valid = 1'b0;
        j = 0;
        for (int i = SRCCOUNT; i >= 1; i--) begin
            j = (int'(ptr) + i) % SRCCOUNT;
            if (((req >> j) & SRCCOUNT'(1)) != '0) begin
                idx = IW'(j);
                valid = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/intc.sv
// intc: forwards one device interrupt at a time to the CPU; software acks via PerInt RW.
// Ports: clk_i, rst_n_i (async active-low); pi1_* PerInt slave (addr/sel unused, rdy tied 1);
// src_intrqst_i/src_intrdy_o device side; intrqst_o/intrdy_i CPU side.
// INTC_FIXEDPRIO_EN: when defined, lowest pending index wins and no round-robin pointer exists.
module intc
    import intc_pkg::*;
#(
    parameter int ARCHBITSZ = 16,
    parameter int SRCCOUNT  = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n_i,
    input  logic [1:0]                                 pi1_op_i,
    input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]                       pi1_data_i,
    output logic [ARCHBITSZ-1:0]                       pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0]                     pi1_sel_i,
    output logic                                       pi1_rdy_o,
    output logic [ARCHBITSZ-1:0]                       pi1_mapsz_o,
    input  logic [SRCCOUNT-1:0]                        src_intrqst_i,
    output logic [SRCCOUNT-1:0]                        src_intrdy_o,
    output logic                                       intrqst_o,
    input  logic                                       intrdy_i
);

    localparam int IW = idx_w(SRCCOUNT);

    state_t                state, state_nxt;
    logic [SRCCOUNT-1:0]   enable, pending;
    logic [IW-1:0]         srcidx, rrptr, pick;
    logic                  pick_vld, intrdy_q, intrdy_negedge, drain_cnt, ack_int;
    logic [ARCHBITSZ-1:0]  rw_data;
    logic                  unused_bits;

    assign unused_bits    = ^{pi1_addr_i, pi1_sel_i, pi1_data_i};
    assign pi1_rdy_o      = 1'b1;
    assign pi1_mapsz_o    = ARCHBITSZ'(((ARCHBITSZ < 64) ? (64 / ARCHBITSZ) : 1) * (ARCHBITSZ / 8));
    assign pending        = src_intrqst_i & enable;
    assign intrqst_o      = (state == REQ);
    assign intrdy_negedge = !intrdy_i && intrdy_q;
    assign ack_int        = (pi1_op_i == PIRWOP) && (pi1_data_i[ARCHBITSZ-1] == CMDACKINT) && (state == WAITACK);
    assign rw_data        = (pi1_data_i[ARCHBITSZ-1] == CMDGETCOUNT) ? ARCHBITSZ'(SRCCOUNT) :
                            (state == WAITACK) ? ARCHBITSZ'(srcidx) : '1;

    intc_rrarb #(.SRCCOUNT(SRCCOUNT), .IW(IW)) u_arb (
        .req   (pending),
        .ptr   (rrptr),
        .idx   (pick),
        .valid (pick_vld)
    );

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && pick_vld)      ? REQ     :
                    (state == REQ && intrdy_negedge) ? WAITACK :
                    ack_int                          ? DRAIN   :
                    (state == DRAIN && drain_cnt)    ? IDLE    : state;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            enable       <= '0;
            srcidx       <= '0;
            drain_cnt    <= 1'b0;
            intrdy_q     <= 1'b1;
            src_intrdy_o <= '1;
            pi1_data_o   <= '0;
        end else begin
            state        <= state_nxt;
            intrdy_q     <= intrdy_i;
            // Two DRAIN cycles let the device's clear reach src_intrqst_i before re-arbitration.
            drain_cnt    <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            src_intrdy_o <= ack_int ? ~(SRCCOUNT'(1) << srcidx) : '1;
            if (state == IDLE && pick_vld) srcidx <= pick;
            if (pi1_op_i == PIWROP) enable <= pi1_data_i[SRCCOUNT-1:0];
            if (pi1_op_i == PIRDOP) pi1_data_o <= ARCHBITSZ'(pending);
            if (pi1_op_i == PIRWOP) pi1_data_o <= rw_data;
        end
    end

`ifndef INTC_FIXEDPRIO_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rrptr <= IW'(SRCCOUNT - 1);
        else if (ack_int) rrptr <= srcidx;
    end
`else
    assign rrptr = '0;
`endif

endmodule

// File: tb/tb_intc.sv
// tb_intc: directed self-checking bench for intc with SRCCOUNT=4, ARCHBITSZ=16.
module tb_intc;
    import intc_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [1:0]  pi1_op_i = PINOOP;
    logic [14:0] pi1_addr_i = '0;
    logic [15:0] pi1_data_i = '0;
    logic [15:0] pi1_data_o;
    logic [1:0]  pi1_sel_i = '0;
    logic        pi1_rdy_o;
    logic [15:0] pi1_mapsz_o;
    logic [3:0]  src_intrqst_i = '0;
    logic [3:0]  src_intrdy_o;
    logic        intrqst_o;
    logic        intrdy_i = 1'b1;

    int n_chk = 0;
    int n_fail = 0;

    intc #(.ARCHBITSZ(16), .SRCCOUNT(4)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .pi1_op_i      (pi1_op_i),
        .pi1_addr_i    (pi1_addr_i),
        .pi1_data_i    (pi1_data_i),
        .pi1_data_o    (pi1_data_o),
        .pi1_sel_i     (pi1_sel_i),
        .pi1_rdy_o     (pi1_rdy_o),
        .pi1_mapsz_o   (pi1_mapsz_o),
        .src_intrqst_i (src_intrqst_i),
        .src_intrdy_o  (src_intrdy_o),
        .intrqst_o     (intrqst_o),
        .intrdy_i      (intrdy_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pi_op(input logic [1:0] op, input logic [15:0] data);
        pi1_op_i = op;
        pi1_data_i = data;
        tick();
        pi1_op_i = PINOOP;
        pi1_data_i = '0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!intrqst_o && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, intrqst_o}, 32'd1);
    endtask

    task automatic serve(input string tag, output logic [15:0] idx);
        wait_req(tag);
        intrdy_i = 1'b0;
        tick();
        intrdy_i = 1'b1;
        pi_op(PIRWOP, 16'h0000);
        idx = pi1_data_o;
    endtask

    logic [15:0] idx;
    logic [15:0] exp_seq [4];

    initial begin
        // Reset values
        #12;
        check("rst_intrdy", {28'd0, src_intrdy_o}, 32'hF);
        check("rst_intrqst", {31'd0, intrqst_o}, 32'd0);
        check("rst_data", {16'd0, pi1_data_o}, 32'd0);
        check("rdy", {31'd0, pi1_rdy_o}, 32'd1);
        check("mapsz", {16'd0, pi1_mapsz_o}, 32'd8);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        pi_op(PIRWOP, 16'h8000);
        check("getcount", {16'd0, pi1_data_o}, 32'd4);
        pi_op(PINOOP, 16'h0000);
        check("data_hold", {16'd0, pi1_data_o}, 32'd4);

        // ACK with nothing outstanding
        pi_op(PIRWOP, 16'h0000);
        check("ack_idle_data", {16'd0, pi1_data_o}, 32'hFFFF);
        check("ack_idle_intrdy", {28'd0, src_intrdy_o}, 32'hF);
        tick();
        check("ack_idle_intrqst", {31'd0, intrqst_o}, 32'd0);

        // Disabled source stays silent until enabled
        src_intrqst_i = 4'b1000;
        tick();
        tick();
        check("dis_intrqst", {31'd0, intrqst_o}, 32'd0);
        pi_op(PIRDOP, 16'h0000);
        check("dis_pending", {16'd0, pi1_data_o}, 32'd0);
        pi_op(PIWROP, 16'h0008);
        check("en_same_cycle", {31'd0, intrqst_o}, 32'd0);
        tick();
        check("en_next_cycle", {31'd0, intrqst_o}, 32'd1);
        pi_op(PIRDOP, 16'h0000);
        check("en_pending", {16'd0, pi1_data_o}, 32'h8);
        intrdy_i = 1'b0;
        tick();
        intrdy_i = 1'b1;
        check("src3_waitack", {31'd0, intrqst_o}, 32'd0);
        pi_op(PIRWOP, 16'h0000);
        check("src3_idx", {16'd0, pi1_data_o}, 32'd3);
        check("src3_pulse", {28'd0, src_intrdy_o}, 32'h7);
        src_intrqst_i = 4'b0000;
        tick();
        check("src3_pulse_end", {28'd0, src_intrdy_o}, 32'hF);
        tick();
        tick();

        // Single source 2, disabled while awaiting ack
        pi_op(PIWROP, 16'h0005);
        src_intrqst_i = 4'b0100;
        check("s2_before", {31'd0, intrqst_o}, 32'd0);
        tick();
        check("s2_req", {31'd0, intrqst_o}, 32'd1);
        tick();
        check("s2_req_hold", {31'd0, intrqst_o}, 32'd1);
        intrdy_i = 1'b0;
        tick();
        intrdy_i = 1'b1;
        check("s2_waitack", {31'd0, intrqst_o}, 32'd0);
        pi_op(PIWROP, 16'h0000);
        pi_op(PIRWOP, 16'h0000);
        check("s2_idx", {16'd0, pi1_data_o}, 32'd2);
        check("s2_pulse", {28'd0, src_intrdy_o}, 32'hB);
        src_intrqst_i = 4'b0000;
        tick();
        check("s2_pulse_end", {28'd0, src_intrdy_o}, 32'hF);
        tick();
        tick();

        // Two held sources alternate under round-robin
`ifdef INTC_FIXEDPRIO_EN
        exp_seq = '{16'd0, 16'd0, 16'd0, 16'd0};
`else
        exp_seq = '{16'd0, 16'd2, 16'd0, 16'd2};
`endif
        pi_op(PIWROP, 16'h0005);
        src_intrqst_i = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            serve("rr_req", idx);
            check($sformatf("rr_idx%0d", i), {16'd0, idx}, {16'd0, exp_seq[i]});
        end
        src_intrqst_i = 4'b0000;
        repeat (4) tick();

        // CPU ack line already low: needs a fresh falling edge
        intrdy_i = 1'b0;
        tick();
        src_intrqst_i = 4'b0001;
        wait_req("low_req");
        repeat (3) tick();
        check("low_still_req", {31'd0, intrqst_o}, 32'd1);
        intrdy_i = 1'b1;
        tick();
        check("low_high_req", {31'd0, intrqst_o}, 32'd1);
        intrdy_i = 1'b0;
        tick();
        intrdy_i = 1'b1;
        check("low_fresh_edge", {31'd0, intrqst_o}, 32'd0);

        // Asynchronous reset while awaiting ack
        #2 rst_n_i = 1'b0;
        #1;
        check("arst_intrqst", {31'd0, intrqst_o}, 32'd0);
        check("arst_intrdy", {28'd0, src_intrdy_o}, 32'hF);
        check("arst_data", {16'd0, pi1_data_o}, 32'd0);
        #1 rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_no_pulse", {28'd0, src_intrdy_o}, 32'hF);
            check("arst_no_req", {31'd0, intrqst_o}, 32'd0);
        end
        pi_op(PIRDOP, 16'h0000);
        check("arst_enable", {16'd0, pi1_data_o}, 32'd0);
        pi_op(PIRWOP, 16'h0000);
        check("arst_idle", {16'd0, pi1_data_o}, 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
